// File: rtl/scan_decoder.sv
// N-to-2**N one-hot decoder with registered outputs and timed
// scan / one-shot sweep sequencing for digit and strobe multiplexing.
module scan_decoder #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            e,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    a,
    input  logic            start,
    output logic [2**N-1:0] d,
    output logic [N-1:0]    idx,
    output logic            busy,
    output logic            done
);

    localparam int W   = 2 ** N;
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DCW-1:0] DC_LAST  = DCW'(DWELL - 1);
    localparam logic [N-1:0]   IDX_LAST = '1;

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_SCAN   = 2'b01,
        M_SWEEP  = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    logic [N-1:0]   idx_q, idx_d;
    logic [DCW-1:0] dc_q, dc_d;
    logic           en_q;
    mode_e          mode_q;
    state_e         state_q, state_d;
    logic           done_q, done_d;

    logic [W-1:0] d_raw;
    logic [W-1:0] d_act;
    logic         blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            dc_q    <= '0;
            en_q    <= 1'b0;
            mode_q  <= M_DIRECT;
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            dc_q    <= dc_d;
            en_q    <= e;
            mode_q  <= mode_e'(mode);
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        dc_d    = dc_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (mode != mode_q) begin
            idx_d   = '0;
            dc_d    = '0;
            state_d = IDLE;
        end else begin
            unique case (mode_q)
                M_DIRECT: begin
                    idx_d = a;
                    dc_d  = '0;
                end
                M_SCAN: begin
                    if (e) begin
                        if (dc_q == DC_LAST) begin
                            dc_d  = '0;
                            idx_d = idx_q + 1'b1;
                        end else begin
                            dc_d = dc_q + 1'b1;
                        end
                    end
                end
                M_SWEEP: begin
                    if (state_q == IDLE) begin
                        if (start && e) begin
                            state_d = SWEEP;
                            idx_d   = '0;
                            dc_d    = '0;
                        end
                    end else if (e) begin
                        if (idx_q == IDX_LAST && dc_q == DC_LAST) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            dc_d    = '0;
                            done_d  = 1'b1;
                        end else if (dc_q == DC_LAST) begin
                            dc_d  = '0;
                            idx_d = idx_q + 1'b1;
                        end else begin
                            dc_d = dc_q + 1'b1;
                        end
                    end
                end
                M_HOLD: begin
                end
            endcase
        end
    end

    // Outputs come from registers only, so d never glitches on input edges.
    assign d_raw = en_q ? (W'(1) << idx_q) : '0;
    assign blank = (mode_q == M_SWEEP) && (state_q == IDLE);
    assign d_act = blank ? '0 : d_raw;
    assign d     = ACTIVE_LOW ? ~d_act : d_act;
    assign idx   = idx_q;
    assign busy  = (state_q == SWEEP);
    assign done  = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: directed cases plus random traffic on two
// parameter sets, checked against a position-count reference model.
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       e;
    logic       start;
    logic [1:0] mode;
    logic [1:0] a0;
    logic [2:0] a1;

    logic [3:0] d0;
    logic [1:0] idx0;
    logic       busy0, done0;
    logic [7:0] d1;
    logic [2:0] idx1;
    logic       busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pos counts enabled cycles within the scan/sweep
    // period, so the selected index is simply pos / DWELL.
    int mm[2];
    int en[2];
    int pos[2];
    int sw[2];
    int dn[2];
    int sel[2];

    scan_decoder #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .e     (e),
        .mode  (mode),
        .a     (a0),
        .start (start),
        .d     (d0),
        .idx   (idx0),
        .busy  (busy0),
        .done  (done0)
    );

    scan_decoder #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .e     (e),
        .mode  (mode),
        .a     (a1),
        .start (start),
        .d     (d1),
        .idx   (idx1),
        .busy  (busy1),
        .done  (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int m;
            int dw;
            int av;
            m  = (k == 0) ? 4 : 8;
            dw = (k == 0) ? 3 : 1;
            av = (k == 0) ? int'(a0) : int'(a1);
            if (reset) begin
                mm[k] = 0; en[k] = 0; pos[k] = 0;
                sw[k] = 0; dn[k] = 0; sel[k] = 0;
            end else begin
                en[k] = int'(e);
                dn[k] = 0;
                if (int'(mode) != mm[k]) begin
                    mm[k] = int'(mode);
                    pos[k] = 0; sw[k] = 0; sel[k] = 0;
                end else if (mm[k] == 0) begin
                    sel[k] = av;
                end else if (mm[k] == 1) begin
                    if (e) pos[k] = (pos[k] + 1) % (m * dw);
                end else if (mm[k] == 2) begin
                    if (sw[k] == 0) begin
                        if (start && e) begin
                            sw[k] = 1;
                            pos[k] = 0;
                        end
                    end else if (e) begin
                        pos[k]++;
                        if (pos[k] == m * dw) begin
                            sw[k] = 0; pos[k] = 0; dn[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int m;
            int dw;
            int ei;
            logic [31:0] ed;
            logic [31:0] mask;
            m    = (k == 0) ? 4 : 8;
            dw   = (k == 0) ? 3 : 1;
            mask = (32'd1 << m) - 1;
            ei   = (mm[k] == 0) ? sel[k] : pos[k] / dw;
            ed   = 0;
            if (en[k] != 0 && !(mm[k] == 2 && sw[k] == 0))
                ed = 32'd1 << ei;
            if (k == 1) ed = ~ed & mask;
            if (k == 0) begin
                chk("d0", 32'(d0), ed);
                chk("idx0", 32'(idx0), 32'(ei));
                chk("busy0", 32'(busy0), 32'(sw[k]));
                chk("done0", 32'(done0), 32'(dn[k]));
            end else begin
                chk("d1", 32'(d1), ed);
                chk("idx1", 32'(idx1), 32'(ei));
                chk("busy1", 32'(busy1), 32'(sw[k]));
                chk("done1", 32'(done1), 32'(dn[k]));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int ndone;
        reset = 1'b1; e = 1'b0; start = 1'b0;
        mode = 2'b00; a0 = '0; a1 = '0;
        tick();
        tick();
        chk("rst_d0", 32'(d0), 32'h0);
        chk("rst_d1", 32'(d1), 32'hFF);
        reset = 1'b0;

        // Direct decode and blanking
        e = 1'b1; a0 = 2'd2; a1 = 3'd5;
        tick();
        chk("dir_d0", 32'(d0), 32'h4);
        chk("dir_d1", 32'(d1), 32'hDF);
        e = 1'b0;
        tick();
        chk("blank_d0", 32'(d0), 32'h0);
        chk("blank_d1", 32'(d1), 32'hFF);

        // Scan from reset release, then pause mid-dwell
        reset = 1'b1; tick();
        reset = 1'b0; mode = 2'b01; e = 1'b1;
        repeat (4) tick();
        chk("scan_d0", 32'(d0), 32'h2);
        e = 1'b0;
        repeat (2) tick();
        e = 1'b1;
        repeat (12) tick();

        // Sweep with a second start mid-sweep
        mode = 2'b10;
        repeat (2) tick();
        start = 1'b1; tick();
        start = 1'b0;
        chk("sw_busy", 32'(busy0), 32'h1);
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            start = (i == 5);
            tick();
            if (done0) ndone++;
        end
        chk("sw_ndone", 32'(ndone), 32'h1);

        // Abort sweep by mode change, then reset mid-scan
        start = 1'b1; tick();
        start = 1'b0;
        repeat (4) tick();
        mode = 2'b00; a0 = 2'd3;
        tick();
        chk("abort_busy", 32'(busy0), 32'h0);
        tick();
        mode = 2'b01;
        repeat (5) tick();
        reset = 1'b1; tick();
        chk("rst_idx", 32'(idx0), 32'h0);
        reset = 1'b0;

        // Hold entry shows index 0
        mode = 2'b11;
        repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0)
                mode = 2'($urandom_range(0, 3));
            e     = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 5) == 0);
            a0    = 2'($urandom);
            a1    = 3'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
